// File: rtl/fetch_pipe_reg.sv
// Fetch-stage sequential boundary: F register (predicted PC), D pipeline register,
// and the F/D/E stall/bubble control for load/use, ret and jump-mispredict hazards.
module fetch_pipe_reg #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] f_predPC,
  input  logic [1:0]      f_stat,
  input  logic [3:0]      f_icode,
  input  logic [3:0]      f_ifun,
  input  logic [3:0]      f_rA,
  input  logic [3:0]      f_rB,
  input  logic [PC_W-1:0] f_valC,
  input  logic [PC_W-1:0] f_valP,
  input  logic [3:0]      d_srcA,
  input  logic [3:0]      d_srcB,
  input  logic [3:0]      E_icode,
  input  logic [3:0]      E_dstM,
  input  logic [3:0]      M_icode,
  input  logic            M_Cnd,
  output logic [PC_W-1:0] F_predPC,
  output logic [1:0]      D_stat,
  output logic [3:0]      D_icode,
  output logic [3:0]      D_ifun,
  output logic [3:0]      D_rA,
  output logic [3:0]      D_rB,
  output logic [PC_W-1:0] D_valC,
  output logic [PC_W-1:0] D_valP,
  output logic            F_stall,
  output logic            D_stall,
  output logic            D_bubble,
  output logic            E_bubble
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef struct packed {
    logic [1:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      rA;
    logic [3:0]      rB;
    logic [PC_W-1:0] valC;
    logic [PC_W-1:0] valP;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{stat: 2'd0, icode: INOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE, valC: '0, valP: '0};

  logic   mispredict, loaduse, ret_pend;
  d_reg_t d_q, d_in;

  // Mispredict is resolved in M, so it overrides any hazard raised by the
  // wrong-path instructions sitting in D and E.
  assign mispredict = (M_icode == IJXX) & ~M_Cnd;
  assign loaduse    = ((E_icode == IMRMOVQ) | (E_icode == IPOPQ)) & (E_dstM != RNONE) &
                      ((E_dstM == d_srcA) | (E_dstM == d_srcB));
  assign ret_pend   = (d_q.icode == IRET) | (E_icode == IRET) | (M_icode == IRET);

  assign F_stall  = ~mispredict & (loaduse | ret_pend);
  assign D_stall  = ~mispredict & loaduse;
  assign D_bubble = mispredict | (~loaduse & ret_pend);
  assign E_bubble = mispredict | loaduse;

  always_ff @(posedge clk) begin
    if (rst)           F_predPC <= RESET_PC;
    else if (!F_stall) F_predPC <= f_predPC;
  end

  assign d_in = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                  valC: f_valC, valP: f_valP};

  always_ff @(posedge clk) begin
    if (rst)            d_q <= D_BUBBLE;
    else if (D_stall)   d_q <= d_q;
    else if (D_bubble)  d_q <= D_BUBBLE;
    else                d_q <= d_in;
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.rA;
  assign D_rB    = d_q.rB;
  assign D_valC  = d_q.valC;
  assign D_valP  = d_q.valP;

endmodule

// File: tb/tb_fetch_pipe_reg.sv
// Directed bench for fetch_pipe_reg: reset, free run, load/use, ret, mispredict, reset mid-stall.
module tb_fetch_pipe_reg;
  localparam int        PC_W = 64;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic clk = 1'b0, rst = 1'b1;
  logic [PC_W-1:0] f_predPC, f_valC, f_valP;
  logic [1:0] f_stat;
  logic [3:0] f_icode, f_ifun, f_rA, f_rB, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic M_Cnd;
  logic [PC_W-1:0] F_predPC, D_valC, D_valP;
  logic [1:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic F_stall, D_stall, D_bubble, E_bubble;
  int total = 0, bad = 0;

  fetch_pipe_reg #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .F_predPC(F_predPC), .D_stat(D_stat),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC),
    .D_valP(D_valP), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    f_predPC = '0; f_stat = 2'd0; f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = '0; f_valP = '0; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; M_icode = 4'h1; M_Cnd = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step();
    total++; if (F_predPC !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", F_predPC, RST_PC); end
    total++; if ({D_stat, D_icode, D_ifun, D_rA, D_rB} !== {2'd0, 4'h1, 4'h0, 4'hF, 4'hF})
      begin bad++; $display("FAIL reset_d got=%h/%h/%h/%h/%h exp=0/1/0/f/f", D_stat, D_icode, D_ifun, D_rA, D_rB); end
    total++; if ({D_valC, D_valP} !== '0) begin bad++; $display("FAIL reset_vals got=%h/%h exp=0/0", D_valC, D_valP); end
  endtask

  task automatic test_free_run();
    rst = 1'b0; f_predPC = 64'h0A; f_icode = 4'h3; f_valC = 64'h64; f_valP = 64'h0A; f_stat = 2'd2;
    #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000)
      begin bad++; $display("FAIL free_ctrl got=%b exp=0000", {F_stall, D_stall, D_bubble, E_bubble}); end
    step();
    total++; if (F_predPC !== 64'h0A) begin bad++; $display("FAIL free_pc got=%h exp=a", F_predPC); end
    total++; if ({D_icode, D_valC, D_valP, D_stat} !== {4'h3, 64'h64, 64'h0A, 2'd2})
      begin bad++; $display("FAIL free_d got=%h/%h/%h/%h exp=3/64/a/2", D_icode, D_valC, D_valP, D_stat); end
  endtask

  task automatic test_loaduse();
    idle(); f_predPC = 64'h20; f_icode = 4'h2; f_rA = 4'h2; f_rB = 4'h4; step();
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    f_predPC = 64'h30; f_icode = 4'h6; f_rA = 4'h7; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101)
      begin bad++; $display("FAIL lu_ctrl got=%b exp=1101", {F_stall, D_stall, D_bubble, E_bubble}); end
    step();
    total++; if ({F_predPC, D_icode, D_rA, D_rB} !== {64'h20, 4'h2, 4'h2, 4'h4})
      begin bad++; $display("FAIL lu_hold got=%h/%h/%h/%h exp=20/2/2/4", F_predPC, D_icode, D_rA, D_rB); end
    E_icode = 4'hB; E_dstM = 4'h3; d_srcA = 4'hF; d_srcB = 4'h3; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101)
      begin bad++; $display("FAIL lu_pop got=%b exp=1101", {F_stall, D_stall, D_bubble, E_bubble}); end
    E_icode = 4'h5; E_dstM = 4'hF; d_srcB = 4'hF; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000)
      begin bad++; $display("FAIL lu_none got=%b exp=0000", {F_stall, D_stall, D_bubble, E_bubble}); end
    E_icode = 4'h2; E_dstM = 4'h3; d_srcB = 4'h3; #1;
    total++; if ({F_stall, D_stall, E_bubble} !== 3'b000)
      begin bad++; $display("FAIL lu_nonload got=%b exp=000", {F_stall, D_stall, E_bubble}); end
    step();
    total++; if ({F_predPC, D_icode, D_rA} !== {64'h30, 4'h6, 4'h7})
      begin bad++; $display("FAIL lu_release got=%h/%h/%h exp=30/6/7", F_predPC, D_icode, D_rA); end
  endtask

  task automatic test_ret();
    idle(); f_predPC = 64'h50; f_icode = 4'h9; step();
    f_predPC = 64'h99; f_icode = 4'h3; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1010)
      begin bad++; $display("FAIL ret_d got=%b exp=1010", {F_stall, D_stall, D_bubble, E_bubble}); end
    step(); E_icode = 4'h9; #1;
    total++; if ({F_predPC, D_icode, F_stall, D_bubble} !== {64'h50, 4'h1, 1'b1, 1'b1})
      begin bad++; $display("FAIL ret_e got=%h/%h/%b/%b exp=50/1/1/1", F_predPC, D_icode, F_stall, D_bubble); end
    step(); E_icode = 4'h1; M_icode = 4'h9; #1;
    total++; if ({F_predPC, F_stall, D_bubble} !== {64'h50, 1'b1, 1'b1})
      begin bad++; $display("FAIL ret_m got=%h/%b/%b exp=50/1/1", F_predPC, F_stall, D_bubble); end
    step(); M_icode = 4'h1; f_predPC = 64'h40; #1;
    total++; if ({F_predPC, F_stall, D_bubble} !== {64'h50, 1'b0, 1'b0})
      begin bad++; $display("FAIL ret_clear got=%h/%b/%b exp=50/0/0", F_predPC, F_stall, D_bubble); end
    step();
    total++; if ({F_predPC, D_icode} !== {64'h40, 4'h3}) begin bad++; $display("FAIL ret_load got=%h/%h exp=40/3", F_predPC, D_icode); end
  endtask

  task automatic test_mispredict();
    idle(); M_icode = 4'h7; M_Cnd = 1'b0; f_predPC = 64'h77; f_icode = 4'h6; f_rA = 4'h1; f_valC = 64'h5; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0011)
      begin bad++; $display("FAIL mp_ctrl got=%b exp=0011", {F_stall, D_stall, D_bubble, E_bubble}); end
    step();
    total++; if ({F_predPC, D_icode, D_rA, D_valC} !== {64'h77, 4'h1, 4'hF, 64'h0})
      begin bad++; $display("FAIL mp_state got=%h/%h/%h/%h exp=77/1/f/0", F_predPC, D_icode, D_rA, D_valC); end
    M_Cnd = 1'b1; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0000)
      begin bad++; $display("FAIL mp_taken got=%b exp=0000", {F_stall, D_stall, D_bubble, E_bubble}); end
  endtask

  task automatic test_mp_loaduse();
    // Put a ret into D first so the mispredict also has to override ret_pend.
    idle(); f_icode = 4'h9; f_predPC = 64'h60; step();
    M_icode = 4'h7; M_Cnd = 1'b0; E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    f_predPC = 64'h88; f_icode = 4'h2; #1;
    total++; if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b0011)
      begin bad++; $display("FAIL mplu_ctrl got=%b exp=0011", {F_stall, D_stall, D_bubble, E_bubble}); end
    step();
    total++; if ({F_predPC, D_icode} !== {64'h88, 4'h1}) begin bad++; $display("FAIL mplu_state got=%h/%h exp=88/1", F_predPC, D_icode); end
  endtask

  task automatic test_reset_stall();
    idle(); f_predPC = 64'hA0; f_icode = 4'h2; f_rA = 4'h5; f_valP = 64'h3; step();
    E_icode = 4'h5; E_dstM = 4'h5; d_srcA = 4'h5; f_predPC = 64'hB0; rst = 1'b1; step();
    total++; if ({F_predPC, D_icode, D_rA, D_valP} !== {RST_PC, 4'h1, 4'hF, 64'h0})
      begin bad++; $display("FAIL rst_stall got=%h/%h/%h/%h exp=1000/1/f/0", F_predPC, D_icode, D_rA, D_valP); end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_loaduse();
    test_ret();
    test_mispredict();
    test_mp_loaduse();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_pipe_reg.md
Name: fetch_pipe_reg

Overview:
- Sequential boundary of the fetch stage in the 5-stage Y86-64 pipeline.
- Contains the F register, which holds the predicted PC. It captures the prediction-logic output and feeds the PC-selection logic on the next cycle.
- Contains the D pipeline register, which holds the fetched instruction fields for decode.
- Contains the stall/bubble control for F, D and E: load/use interlock, ret handling, and jump-mispredict squash. Mispredict is detected in M, so it is consistent with PC correction from M_valA.

Parameters:
- PC_W, 64, width of PC/valC/valP.
- RESET_PC, 64'h0, F_predPC value after reset.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- f_predPC  in  PC_W  predicted next PC from prediction logic.
- f_stat  in  2  fetch status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- f_icode  in  4  fetched icode.
- f_ifun  in  4  fetched ifun.
- f_rA  in  4  fetched rA (4'hF = none).
- f_rB  in  4  fetched rB (4'hF = none).
- f_valC  in  PC_W  fetched constant.
- f_valP  in  PC_W  fall-through PC.
- d_srcA  in  4  decode source A (combinational from D).
- d_srcB  in  4  decode source B (combinational from D).
- E_icode  in  4  icode in execute register.
- E_dstM  in  4  memory destination in execute register.
- M_icode  in  4  icode in memory register.
- M_Cnd  in  1  branch condition in memory register.
- F_predPC  out  PC_W  registered predicted PC.
- D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP  out  2/4/4/4/4/PC_W/PC_W  decode register.
- F_stall  out  1  F held this cycle.
- D_stall  out  1  D held this cycle.
- D_bubble  out  1  D loaded with bubble this cycle.
- E_bubble  out  1  request to E register to insert a bubble.

Behaviour:
Combinational hazard terms:
- mispredict = (M_icode==7) & ~M_Cnd.
- loaduse = (E_icode==5 | E_icode==0xB) & (E_dstM!=4'hF) & (E_dstM==d_srcA | E_dstM==d_srcB).
- ret_pend = D_icode==9 | E_icode==9 | M_icode==9.

Control outputs (combinational, mispredict has highest priority):
- F_stall = ~mispredict & (loaduse | ret_pend).
- D_stall = ~mispredict & loaduse.
- D_bubble = mispredict | (~loaduse & ret_pend).
- E_bubble = mispredict | loaduse.
- D_stall and D_bubble are never both 1.

F register (posedge):
- rst: F_predPC <= RESET_PC.
- else if F_stall: hold.
- else: F_predPC <= f_predPC.
- Latency 1 cycle.

D register (posedge), priority rst > D_stall > D_bubble > load:
- rst: load the bubble value.
- D_stall: hold all fields.
- D_bubble: load the bubble value.
- load: capture all f_* fields.
- Bubble value: stat 0 (AOK), icode 1 (nop), ifun 0, rA 4'hF, rB 4'hF, valC 0, valP 0.
- Latency 1 cycle.

Reset:
- Reset is synchronous. Asserting rst mid-stall or mid-ret sequence discards the held state on the next edge.
- After reset: F_predPC = RESET_PC; D holds a bubble.
- Control outputs are combinational and reflect pipeline inputs during reset; they are don't-care for state while rst=1.

Boundary cases:
- src = 4'hF never matches because E_dstM = 4'hF is excluded.
- Mispredict together with a loaduse caused by wrong-path D/E instructions: mispredict wins. F loads the corrected PC, D bubbles, E bubbles, no stall.
- Ret already in D, wrong path under mispredict: ignored; D bubbles.
- Consecutive ret sequence: F stays stalled 3 cycles (ret in D, E, M). F loads when ret reaches W (M_icode!=9, E/D bubbles).
- No internal counters. Stall duration is fully determined by the pipeline inputs each cycle.

Test Plan:
1. Reset then free run:
   - rst=1 one cycle -> F_predPC=0, D_icode=1, D_rA=F.
   - Release with f_predPC=0x0A, f_icode=3, f_valC=0x64 -> next edge F_predPC=0x0A, D_icode=3, D_valC=0x64.
2. Load/use:
   - E_icode=5, E_dstM=2, d_srcA=2 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
   - F_predPC and D fields unchanged over the edge.
   - Same with E_dstM=F -> no stall.
3. Ret:
   - D_icode=9 -> F_stall=1, D_bubble=1.
   - Drive E_icode=9, then M_icode=9 -> stall/bubble persist.
   - All three cleared -> F loads f_predPC=0x40.
4. Mispredict:
   - M_icode=7, M_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; D=nop after edge.
   - M_Cnd=1 -> no action.
5. Simultaneous mispredict + loaduse (E_icode=5, E_dstM=d_srcB=3) -> mispredict wins: F_stall=0, D_stall=0, D_bubble=1.
6. Reset during stall (loaduse held, rst=1) -> next edge F_predPC=RESET_PC, D = bubble value.
